// File: rtl/tile_spawner_if.sv
// Spawn request / preset bus between the game controller and the tile spawner.
// Latency: none, this is wiring only.
// Backpressure: none; the requester reads busy and done to pace itself.
interface tile_spawner_if #(
  parameter int N_CELLS = 16,
  parameter int VAL_W   = 4
);
  logic                       start;
  logic                       double;
  logic [N_CELLS*VAL_W-1:0]   board_values;
  logic [N_CELLS-1:0]         preset_ext;
  logic [VAL_W-1:0]           value_preset;
  logic                       busy;
  logic                       done;
  logic                       board_full;

  // Requester side: issues spawn requests and watches the presets.
  modport master (
    output start, double, board_values,
    input  preset_ext, value_preset, busy, done, board_full
  );

  // Spawner side.
  modport slave (
    input  start, double, board_values,
    output preset_ext, value_preset, busy, done, board_full
  );
endinterface

// File: rtl/tile_spawner.sv
// Places a new tile (2 or 4) in a pseudo-randomly chosen empty cell of the node array.
// Latency: preset 2 cycles after start when the start cell is empty, +1 cycle per scan step.
// Backpressure: start is sampled only while idle; requests arriving while busy are dropped.
module tile_spawner #(
  parameter int          N_CELLS   = 16,
  parameter int          VAL_W     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [3:0]  P4_THRESH = 4'd2
) (
  input  logic          clk,
  input  logic          rst,
  tile_spawner_if.slave bus
);

  localparam int IDX_W = $clog2(N_CELLS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CELLS - 1);
  localparam logic [IDX_W:0]   CNT_LAST = (IDX_W+1)'(N_CELLS - 1);

  logic [1:0]         r_state;
  logic [15:0]        r_lfsr;
  logic [N_CELLS-1:0] r_mask;
  logic               r_second;
  logic [IDX_W-1:0]   r_idx;
  logic [VAL_W-1:0]   r_val;
  logic [IDX_W:0]     r_count;
  logic               r_board_full;

  logic [N_CELLS-1:0] w_empty;
  logic [N_CELLS-1:0] w_onehot;
  logic [N_CELLS-1:0] w_mask_after;
  logic [15:0]        w_lfsr_next;
  logic [IDX_W-1:0]   w_lfsr_idx;
  logic [VAL_W-1:0]   w_lfsr_val;
  logic [IDX_W-1:0]   w_idx_next;

  // A cell is free when its exponent is zero.
  genvar gi;
  generate
    for (gi = 0; gi < N_CELLS; gi++) begin : g_empty
      assign w_empty[gi] = (bus.board_values[gi*VAL_W +: VAL_W] == '0);
    end
  endgenerate

  // Galois step for x^16+x^14+x^13+x^11+1; a stuck-at-zero register is reseeded.
  assign w_lfsr_next = (r_lfsr == 16'd0) ? LFSR_SEED
                     : ({1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000));

  // Start cell and tile value are both drawn from the current LFSR state.
  assign w_lfsr_idx   = r_lfsr[IDX_W-1:0];
  assign w_lfsr_val   = (r_lfsr[7:4] < P4_THRESH) ? VAL_W'(2) : VAL_W'(1);
  assign w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
  assign w_onehot     = N_CELLS'(1) << r_idx;
  assign w_mask_after = r_mask & ~w_onehot;

  // Outputs decode from state only, so reset clears them immediately.
  assign bus.preset_ext   = (r_state == S_WRITE) ? w_onehot : '0;
  assign bus.value_preset = (r_state == S_WRITE) ? r_val : '0;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.board_full   = r_board_full;

  // Free-running LFSR, advances every cycle regardless of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // Request sequencer: latch mask, scan forward from the random cell, preset, finish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_second     <= 1'b0;
      r_idx        <= '0;
      r_val        <= '0;
      r_count      <= '0;
      r_board_full <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mask       <= w_empty;
            r_second     <= bus.double;
            r_board_full <= 1'b0;
            if (w_empty == '0) begin
              r_board_full <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_idx   <= w_lfsr_idx;
              r_val   <= w_lfsr_val;
              r_count <= '0;
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (r_mask[r_idx]) begin
            r_state <= S_WRITE;
          end else begin
            r_idx   <= w_idx_next;
            r_count <= r_count + (IDX_W+1)'(1);
            // Cannot trigger with a non-empty latched mask; kept so a bad mask never hangs.
            if (r_count == CNT_LAST) begin
              r_board_full <= 1'b1;
              r_state      <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          r_mask <= w_mask_after;
          if (r_second && (w_mask_after != '0)) begin
            r_second <= 1'b0;
            r_idx    <= w_lfsr_idx;
            r_val    <= w_lfsr_val;
            r_count  <= '0;
            r_state  <= S_SCAN;
          end else if (r_second) begin
            r_second     <= 1'b0;
            r_board_full <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
